// File: rtl/arm_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : arm_fetch_stage
// Description : ARM 5-stage pipeline instruction fetch with IF/ID register,
//               hazard freeze, branch redirect/flush and retired-fetch count.
// Revision    : 1.0
// ============================================================================
module arm_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    // Low bits are forced clear so a misaligned parameter can never leak out.
    localparam logic [31:0] C_RESET_PC = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q,          pc_d;
    logic [31:0] id_pc_q,       id_pc_d;
    logic [31:0] id_instr_q,    id_instr_d;
    logic        id_valid_q,    id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d          = pc_q;
        id_pc_d       = id_pc_q;
        id_instr_d    = id_instr_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;

        // A redirect overrides a stall: the word at the current PC is dropped.
        if (branch_taken) begin
            pc_d       = {branch_addr[31:2], 2'b00};
            id_pc_d    = 32'd0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (!freeze) begin
            pc_d          = w_pc_plus4;
            id_pc_d       = w_pc_plus4;
            id_instr_d    = imem_instr;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= C_RESET_PC;
            id_pc_q       <= 32'd0;
            id_instr_q    <= NOP_INSTR;
            id_valid_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_pc       = id_pc_q;
    assign id_instr    = id_instr_q;
    assign id_valid    = id_valid_q;
    assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: doc/arm_fetch_stage.md
# arm_fetch_stage

Instruction-fetch stage of the 5-stage ARM pipeline. Holds the program counter, drives the address of the combinational instruction memory, and registers the returned word into the IF/ID pipeline register for the decode stage. Handles hazard freeze from the hazard unit and branch redirect/flush from the execute stage. Keeps a retired-fetch counter for debug.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0000: word loaded into id_instr on reset and flush.

- clk  in  1: sole clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- freeze  in  1: hazard stall; hold the PC and IF/ID register.
- branch_taken  in  1: execute-stage redirect; flush IF/ID and load the PC.
- branch_addr  in  32: redirect target; bits [1:0] ignored (treated as 00).
- imem_addr  out  32: PC, driven combinationally to the instruction memory Address.
- imem_instr  in  32: instruction memory read data; combinational from imem_addr in the same cycle.
- id_pc  out  32: registered PC+4 of the instruction in IF/ID.
- id_instr  out  32: registered instruction word.
- id_valid  out  1: IF/ID holds a real instruction (0 = bubble).
- fetch_count  out  32: number of instructions latched into IF/ID with id_valid=1.

## Operation
- State: PC (32), IF/ID {id_pc, id_instr, id_valid}, fetch_count.
- imem_addr = PC at all times. PC[1:0] is always 00.
- Each rising edge applies the highest-priority case below.
- rst: asynchronous. PC=RESET_PC, id_pc=0, id_instr=NOP_INSTR, id_valid=0, fetch_count=0. Outputs take these values immediately on rst assertion, independent of clk.
- branch_taken=1: PC ← {branch_addr[31:2],2'b00}, id_instr ← NOP_INSTR, id_valid ← 0, id_pc ← 0. fetch_count is unchanged.
  - Takes priority over freeze. The instruction at the current PC is discarded.
- freeze=1 (no branch): PC, IF/ID and fetch_count all hold.
- Normal: id_instr ← imem_instr, id_pc ← PC+4, id_valid ← 1, PC ← PC+4, fetch_count ← fetch_count+1.
- Arithmetic: PC+4 is mod 2^32, so 32'hFFFF_FFFC wraps to 0. fetch_count wraps mod 2^32.
- The stage does not evaluate condition codes. Conditional and branch words pass through unchanged.

## Timing
- Fetch latency is 1 cycle: the word at PC is presented on id_instr after the next rising edge.
- Branch penalty inside this stage:
  - The edge with branch_taken=1 inserts one bubble.
  - The target word appears in IF/ID after the following edge, unless that edge is frozen.
- Freeze may last any number of cycles. Consecutive freeze cycles leave the outputs unchanged.
- After rst deasserts, the first normal edge latches the word at RESET_PC.
- A branch and a freeze in the same cycle: the branch executes in full and the freeze is ignored for that edge.
- Reset deasserted mid-cycle: behaviour is fully defined by the next edge; no partial state remains.
- branch_addr is sampled only on edges where branch_taken=1.

## Test plan
- Reset and sequential fetch:
  - Stimulus: rst pulse, memory word0=32'hE3A0_0014, word1=32'hE3A0_1A01.
  - During reset: imem_addr=0, id_valid=0, fetch_count=0.
  - Edge 1: id_instr=E3A00014, id_pc=4, imem_addr=4.
  - Edge 2: id_instr=E3A01A01, id_pc=8, fetch_count=2.
- Freeze: assert freeze for 3 edges after edge 1 → imem_addr stays 4, id_instr stays E3A00014, fetch_count stays 1. Deassert → next edge id_instr=E3A01A01.
- Branch flush:
  - Stimulus: at PC=0x10, branch_taken=1, branch_addr=0x1F.
  - Next edge: id_valid=0, id_instr=NOP_INSTR, imem_addr=0x1C, fetch_count unchanged.
  - Following edge: id_pc=0x20, id_valid=1.
- Branch and freeze together: freeze=1, branch_taken=1, branch_addr=0x40 → imem_addr=0x40, id_valid=0.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, one normal edge → id_pc=0, imem_addr=0.
- Async reset mid-run: assert rst between edges after 5 fetches → outputs return to reset values before the next clk edge. Fetch then restarts at RESET_PC.
